mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage, lw/sw) of the pipelined CPU.
- Registered FSM: grants one requester at a time and holds the memory request until the memory's ready.
- Returns read data and a one-cycle completion pulse to the granted port.
- Produces a stall signal for the pipeline control.
- Data has priority; a starvation counter guarantees fetch progress.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory arbiter state encodings and default widths.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  // Arbiter FSM encodings (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC_I = 2'd1;
  localparam logic [1:0] ST_ACC_D = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and
// the data (lw/sw) port. Data has priority; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants with fetch pending.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_stall
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       grant_d;

  // Data wins unless fetch has been passed over STARVE_MAX times in a row
  assign grant_d   = d_req && (!if_req || (starve_cnt < STARVE_LIM));
  assign mem_stall = (if_req && !if_ready) || (d_req && !d_ready);

  // Arbitration FSM; access outputs are latched at grant and held until mem_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_ACC_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req)
              starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end else if (if_req) begin
            state      <= ST_ACC_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end
        end
        ST_ACC_I: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            mem_req  <= 1'b0;
            if_ready <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_ACC_D: begin
          if (mem_ready) begin
            // Stores leave the last load value in place
            if (!mem_we) d_rdata <= mem_rdata;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            state   <= ST_RESP;
          end
        end
        // Ready pulse cycle: lets the served requester drop req before re-arbitration
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions and
// memory accesses; independent monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, if_ready, d_req, d_we, d_ready;
  logic        mem_req, mem_we, mem_ready, mem_stall;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct { logic port; logic [31:0] data; } rsp_t;  // port 0=I, 1=D
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int len; } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat     = 0;
  int   acc_cyc = 0;
  logic [31:0] mem_arr [0:255];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ready after lat extra cycles, word indexed
  assign mem_ready = mem_req && (acc_cyc == lat);
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!reset) begin
      mem_arr[4]  <= 32'h8C010004;
      mem_arr[8]  <= 32'h24020005;
      mem_arr[12] <= 32'h20420001;
      mem_arr[16] <= 32'h11111111;
      mem_arr[17] <= 32'hCAFEF00D;
      mem_arr[18] <= 32'h0BADF00D;
      mem_arr[19] <= 32'h600DCAFE;
    end else if (mem_req && mem_ready && mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
    acc_cyc <= (mem_req && !mem_ready) ? acc_cyc + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_ready && d_ready) check("both_ready", 1, 0);
      if ((if_ready || d_ready) && mem_req) check("mem_req_in_resp", mem_req, 0);
      if (if_ready || d_ready) begin
        if (rsp_q.size() == 0) check("spurious_ready", {if_ready, d_ready}, 0);
        else begin
          r = rsp_q.pop_front();
          check("ready_port", d_ready, r.port);
          check(r.port ? "d_rdata" : "if_rdata", r.port ? d_rdata : if_rdata, r.data);
        end
      end
    end
  end

  // Memory access monitor: order, attributes, stability and duration
  initial begin
    acc_t cur;
    logic prev = 1'b0;
    int   cyc  = 0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, len: 0};
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!prev) begin
          cyc = 1;
          if (acc_q.size() == 0) check("spurious_access", mem_addr, 32'hFFFFFFFF);
          else begin
            cur = acc_q.pop_front();
            check("acc_we", mem_we, cur.we);
            check("acc_addr", mem_addr, cur.addr);
            if (cur.we) check("acc_wdata", mem_wdata, cur.wdata);
          end
        end else begin
          cyc++;
          check("acc_stable", {mem_addr ^ cur.addr, 31'h0, mem_we ^ cur.we}, 0);
        end
      end else if (prev && cur.len != 0) begin
        check("acc_len", cyc, cur.len);
      end
      prev = mem_req;
    end
  end

  task automatic wait_ready(input bit is_d, input bit chk_stall);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) begin ok = 1; break; end
      if (chk_stall) check("stall_wait", mem_stall, 1);
    end
    if (!ok) check("ready_timeout", is_d, ~is_d);
  endtask

  task automatic drive_i(input logic [31:0] addr, input bit chk_stall);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    wait_ready(1'b0, chk_stall);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    wait_ready(1'b1, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_readys", {if_ready, d_ready}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_stall", mem_stall, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Single fetch, zero wait states: mem_req cycle 1 only, ready cycle 2
    lat = 0;
    rsp_q.push_back(rsp_t'{1'b0, 32'h8C010004});
    acc_q.push_back(acc_t'{1'b0, 32'h10, 32'h0, 1});
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("f_c0_mem_req", mem_req, 0);
    check("f_c0_stall", mem_stall, 1);
    @(negedge clk);
    check("f_c1_mem_req", mem_req, 1);
    check("f_c1_if_ready", if_ready, 0);
    @(negedge clk);
    check("f_c2_if_ready", if_ready, 1);
    check("f_c2_mem_req", mem_req, 0);
    check("f_c2_stall", mem_stall, 0);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    check("f_c3_if_ready", if_ready, 0);

    // Store then load of the same word
    lat = 1;
    acc_q.push_back(acc_t'{1'b1, 32'h40, 32'hDEADBEEF, 2});
    rsp_q.push_back(rsp_t'{1'b1, 32'h0});
    drive_d(1'b1, 32'h40, 32'hDEADBEEF);
    lat = 0;
    acc_q.push_back(acc_t'{1'b0, 32'h40, 32'h0, 1});
    rsp_q.push_back(rsp_t'{1'b1, 32'hDEADBEEF});
    drive_d(1'b0, 32'h40, 32'h0);

    // Simultaneous requests: data first, then fetch
    lat = 2;
    acc_q.push_back(acc_t'{1'b0, 32'h44, 32'h0, 3});
    acc_q.push_back(acc_t'{1'b0, 32'h20, 32'h0, 3});
    rsp_q.push_back(rsp_t'{1'b1, 32'hCAFEF00D});
    rsp_q.push_back(rsp_t'{1'b0, 32'h24020005});
    fork
      drive_i(32'h20, 1'b0);
      drive_d(1'b0, 32'h44, 32'h0);
    join

    // Starvation: four data grants, forced fetch, then data again
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back(acc_t'{1'b0, 32'h48, 32'h0, 2});
      rsp_q.push_back(rsp_t'{1'b1, 32'h0BADF00D});
    end
    acc_q.push_back(acc_t'{1'b0, 32'h30, 32'h0, 2});
    rsp_q.push_back(rsp_t'{1'b0, 32'h20420001});
    acc_q.push_back(acc_t'{1'b0, 32'h48, 32'h0, 2});
    rsp_q.push_back(rsp_t'{1'b1, 32'h0BADF00D});
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    wait_ready(1'b0, 1'b0);
    @(posedge clk); #1 if_req = 1'b0;
    wait_ready(1'b1, 1'b0);
    @(posedge clk); #1 d_req = 1'b0;

    // Counter back at zero: simultaneous requests again serve data first
    lat = 0;
    acc_q.push_back(acc_t'{1'b0, 32'h40, 32'h0, 1});
    acc_q.push_back(acc_t'{1'b0, 32'h10, 32'h0, 1});
    rsp_q.push_back(rsp_t'{1'b1, 32'hDEADBEEF});
    rsp_q.push_back(rsp_t'{1'b0, 32'h8C010004});
    fork
      drive_i(32'h10, 1'b0);
      drive_d(1'b0, 32'h40, 32'h0);
    join

    // Five wait states: request held stable six cycles, stall throughout
    lat = 5;
    acc_q.push_back(acc_t'{1'b0, 32'h20, 32'h0, 6});
    rsp_q.push_back(rsp_t'{1'b0, 32'h24020005});
    drive_i(32'h20, 1'b1);

    // Reset mid-access: abandoned load, then re-arbitrated after release
    lat = 3;
    acc_q.push_back(acc_t'{1'b0, 32'h4C, 32'h0, 0});
    acc_q.push_back(acc_t'{1'b0, 32'h4C, 32'h0, 4});
    rsp_q.push_back(rsp_t'{1'b1, 32'h600DCAFE});
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4C;
    @(negedge clk);
    @(negedge clk);
    check("rm_mem_req_before", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rm_mem_req_async", mem_req, 0);
    check("rm_d_rdata_clr", d_rdata, 0);
    @(negedge clk);
    check("rm_no_ready", d_ready, 0);
    @(posedge clk); #1 reset = 1'b1;
    wait_ready(1'b1, 1'b0);
    @(posedge clk); #1 d_req = 1'b0;

    repeat (5) @(negedge clk);
    check("rsp_q_empty", 32'(rsp_q.size()), 0);
    check("acc_q_empty", 32'(acc_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
